prio_burst_arbiter: RTL and testbench
=====================================

Name: prio_burst_arbiter

Overview:
Shares the single priority-select output path between N_REQ requesters, one burst at a time. It registers one arbitration decision per burst and holds the grant until the beat marked last. It drives one registered valid/ready output stage. Fixed priority (lowest index wins) is the default; a saturating per-lane age counter promotes starved lanes so the low-priority fall-through lanes are always served eventually.

Parameters:
N_REQ, 5, number of requesters (2..8)
DATA_W, 8, data width per beat
AGE_MAX, 7, lost arbitrations before a lane is promoted; 0 disables aging (pure fixed priority)
ID_W, 3, width of out_id; must be >= clog2(N_REQ)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-lane beat valid
req_data  input  N_REQ*DATA_W  per-lane beat data; lane i at [i*DATA_W +: DATA_W]
req_last  input  N_REQ  per-lane last-beat-of-burst flag
req_ready  output  N_REQ  per-lane accept; at most one bit high
out_valid  output  1  output register holds a beat
out_data  output  DATA_W  registered beat data
out_id  output  ID_W  lane index of the registered beat
out_last  output  1  registered last flag
out_ready  input  1  downstream accept
busy  output  1  high in BURST state

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, cur_id=0, all age counters 0, out_valid=0, out_data=0, out_id=0, out_last=0, req_ready=0, busy=0. Reset mid-burst drops the in-flight beat and the burst with no flush.
- FSM states: IDLE, BURST.
- IDLE: if any req_valid bit is high, the winner is selected combinationally, and on that edge: cur_id=winner, state=BURST. req_ready=0 throughout IDLE. A burst costs exactly 1 arbitration cycle before its first beat can be accepted.
- Winner rule: if any lane with req_valid=1 has age==AGE_MAX (and AGE_MAX>0), the lowest-index such lane wins. Otherwise the lowest-index valid lane wins.
- Aging, applied on the arbitration edge only: winner age := 0; every other lane with req_valid=1 gets age := min(age+1, AGE_MAX); non-requesting lanes hold their age.
- BURST: req_ready[cur_id] = (!out_valid || out_ready); all other req_ready bits are 0. busy=1.
- Beat accept is req_valid[cur_id] && req_ready[cur_id]. On accept, the output register loads data, id=cur_id and last, and out_valid is set to 1. The path sustains 1 beat/cycle when out_ready is held high.
- Output drain: out_valid && out_ready with no new accept sets out_valid to 0. A simultaneous drain and accept loads the new beat and keeps out_valid=1.
- Accept with req_last=1 sets state=IDLE on the same edge. The next burst is arbitrated the following cycle (1 bubble).
- Locked lane deasserts req_valid mid-burst: remain in BURST indefinitely with no timeout. Other lanes stay blocked.
- out_ready low: out_data, out_id and out_last hold stable while out_valid=1; no new accept.
- Single-beat burst (req_last=1 on the first beat) is legal: IDLE→BURST→IDLE, 2 cycles per beat per burst.
- out_id is zero-extended to ID_W.

Test Plan:
- Reset mid-burst: lane 2 in BURST with out_valid=1, pulse rst_n low -> outputs 0 and state IDLE immediately; after release, lane 1 requesting gets the next grant.
- Fixed priority: req_valid=5'b10110, 3-beat bursts on each lane, out_ready=1 -> bursts appear in order id 1, 2, 4; each burst's beats are contiguous, with 1 idle cycle between bursts.
- Backpressure: lane 0 bursts data 0x11, 0x22, 0x33(last); out_ready low for 4 cycles after the first beat -> out_data holds 0x11, req_ready[0]=0 during the stall, and no beat is lost or duplicated.
- Aging with AGE_MAX=2: lane 0 streams back-to-back 1-beat bursts, lane 4 held valid -> lane 4 is granted on the 3rd arbitration and its age is cleared.
- AGE_MAX=0: same stimulus -> lane 4 is never granted while lane 0 keeps requesting.
- Locked lane stalls: lane 3 drops req_valid after beat 1 while lane 0 is requesting -> busy stays 1, no lane-0 beats are accepted until lane 3 completes with last.

Source files
------------

// File: rtl/prio_burst_arbiter.sv
// Burst arbiter: one registered grant decision per burst (fixed priority with
// age-based promotion) feeding a single registered valid/ready output stage.
module prio_burst_arbiter #(
  parameter int N_REQ   = 5,
  parameter int DATA_W  = 8,
  parameter int AGE_MAX = 7,
  parameter int ID_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int AGE_W = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   cur_id, winner;
  logic [AGE_W-1:0]  age [N_REQ];
  logic [N_REQ-1:0]  cur_sel;
  logic              accept;
  logic              arbitrate;
  logic [DATA_W-1:0] cur_data;
  logic              cur_last;

  // Promoted (starved) lanes take precedence; ties in either class go to the lowest index.
  always_comb begin
    logic            aged_hit;
    logic [ID_W-1:0] aged_idx, low_idx;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    aged_hit = 1'b0;
    aged_idx = '0;
    low_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        low_idx = ID_W'(i);
        if (AGE_MAX > 0 && age[i] == AGE_TOP) begin
          aged_hit = 1'b1;
          aged_idx = ID_W'(i);
        end
      end
    end
    winner = aged_hit ? aged_idx : low_idx;
  end

  assign arbitrate = (state == IDLE) && (|req_valid);
  assign cur_sel   = N_REQ'(1) << cur_id;
  assign req_ready = (state == BURST) ? (cur_sel & {N_REQ{!out_valid || out_ready}}) : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state == BURST);

  always_comb begin
    cur_data = '0;
    cur_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cur_sel[i]) begin
        cur_data = req_data[i*DATA_W +: DATA_W];
        cur_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req_valid) state_next = BURST;
      BURST:   if (accept && cur_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur_id <= '0;
    end else begin
      state <= state_next;
      if (arbitrate) cur_id <= winner;
    end
  end

  // NOTE: the age array is reset because its contents steer arbitration; a storage-only array would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) age[i] <= '0;
    end else if (arbitrate) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ID_W'(i) == winner)                  age[i] <= '0;
        else if (req_valid[i] && age[i] != AGE_TOP) age[i] <= age[i] + 1'b1;
      end
    end
  end

  // A new accept always overwrites; otherwise a downstream take empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= cur_data;
      out_id    <= cur_id;
      out_last  <= cur_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_burst_arbiter.sv
// Scoreboard bench: lane sources feed the default DUT; two extra instances
// (AGE_MAX=2 and AGE_MAX=0) run a fixed two-lane pattern for the aging rule.
module tb_prio_burst_arbiter;
  localparam int N = 5;

  typedef struct {logic [7:0] data; logic last; int gap;} beat_t;
  typedef struct {logic [2:0] id; logic [7:0] data; logic last; int dt;} exp_t;

  logic         clk, rst_n, rst2_n;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*8-1:0] req_data;
  logic         out_valid, out_last, out_ready, busy;
  logic [7:0]   out_data;
  logic [2:0]   out_id;

  logic [N-1:0]   a_req_valid, a_req_last;
  logic [N*8-1:0] a_req_data;
  logic           a_out_ready;
  logic [N-1:0]   ag_req_ready, fx_req_ready;
  logic           ag_out_valid, ag_out_last, ag_busy, fx_out_valid, fx_out_last, fx_busy;
  logic [7:0]     ag_out_data, fx_out_data;
  logic [2:0]     ag_out_id, fx_out_id;

  beat_t      src_q [N][$];
  exp_t       exp_q[$];
  logic [2:0] exp_a[$], exp_f[$];
  int n_checks = 0, n_fail = 0, cyc = 0;

  prio_burst_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_ready(out_ready), .busy(busy));

  prio_burst_arbiter #(.AGE_MAX(2)) u_aged (
    .clk(clk), .rst_n(rst2_n), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_last(a_req_last), .req_ready(ag_req_ready), .out_valid(ag_out_valid),
    .out_data(ag_out_data), .out_id(ag_out_id), .out_last(ag_out_last),
    .out_ready(a_out_ready), .busy(ag_busy));

  prio_burst_arbiter #(.AGE_MAX(0)) u_fixed (
    .clk(clk), .rst_n(rst2_n), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_last(a_req_last), .req_ready(fx_req_ready), .out_valid(fx_out_valid),
    .out_data(fx_out_data), .out_id(fx_out_id), .out_last(fx_out_last),
    .out_ready(a_out_ready), .busy(fx_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Presents the head beat of each lane queue; a non-zero gap holds the lane invalid.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && src_q[i][0].gap == 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*8 +: 8]    = src_q[i][0].data;
        req_last[i]           = src_q[i][0].last;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*8 +: 8]    = 8'h00;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  // One clock: handshakes are sampled at the negedge, inputs updated 1 ns after the posedge.
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      else if (src_q[i].size() > 0 && src_q[i][0].gap > 0) src_q[i][0].gap--;
    end
    drive();
  endtask

  task automatic load(input int lane, input logic [7:0] d, input logic l, input int g, input int dt);
    beat_t b;
    exp_t  e;
    b.data = d; b.last = l; b.gap = g;
    src_q[lane].push_back(b);
    e.id = 3'(lane); e.data = d; e.last = l; e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    if (exp_q.size() != 0) fail_timeout(name);
  endtask

  // Scoreboard monitors: compare every beat taken downstream against the queued expectation.
  initial begin
    exp_t e;
    int   last_cyc;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_id", 32'(out_id), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_id",   32'(out_id),   32'(e.id));
          check("beat_data", 32'(out_data), 32'(e.data));
          check("beat_last", 32'(out_last), 32'(e.last));
          if (e.dt > 0) check("beat_spacing", 32'(cyc - last_cyc), 32'(e.dt));
        end
        last_cyc = cyc;
      end
    end
  end

  initial forever begin
    logic [2:0] id;
    @(negedge clk);
    if (ag_out_valid && a_out_ready && exp_a.size() > 0) begin
      id = exp_a.pop_front();
      check("aged_id",   32'(ag_out_id),   32'(id));
      check("aged_data", 32'(ag_out_data), (id == 3'd0) ? 32'hA0 : 32'hE4);
      check("aged_last", 32'(ag_out_last), 32'd1);
    end
    if (fx_out_valid && a_out_ready && exp_f.size() > 0) begin
      id = exp_f.pop_front();
      check("fixed_id",   32'(fx_out_id),   32'(id));
      check("fixed_data", 32'(fx_out_data), (id == 3'd0) ? 32'hA0 : 32'hE4);
      check("fixed_last", 32'(fx_out_last), 32'd1);
    end
  end

  initial begin
    int k;
    rst_n = 1'b0; rst2_n = 1'b0; out_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    a_req_valid = 5'b10001; a_req_last = 5'b11111; a_out_ready = 1'b1;
    a_req_data = '0;
    a_req_data[0*8 +: 8] = 8'hA0;
    a_req_data[4*8 +: 8] = 8'hE4;
    // AGE_MAX=2: lane 4 wins every 3rd arbitration; AGE_MAX=0: lane 0 always.
    exp_a = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd4};
    exp_f = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    drive();
    cycle();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    cycle();
    rst_n = 1'b1; rst2_n = 1'b1;

    // Reset mid-burst: lane 2 stalled with a beat held in the output register.
    src_q[2].push_back('{8'h21, 1'b0, 0});
    src_q[2].push_back('{8'h22, 1'b0, 0});
    src_q[2].push_back('{8'h23, 1'b1, 0});
    drive();
    k = 0;
    while (!out_valid && k < 10) begin cycle(); k++; end
    if (!out_valid) fail_timeout("lane2_first_beat");
    check("pre_rst_busy",   32'(busy), 1);
    check("pre_rst_out_id", 32'(out_id), 2);
    check("pre_rst_data",   32'(out_data), 32'h21);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_busy",      32'(busy), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_out_data",  32'(out_data), 0);
    check("mid_rst_out_id",    32'(out_id), 0);
    check("mid_rst_out_last",  32'(out_last), 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive();
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    load(2, 8'h2A, 1'b1, 0, 0);
    load(1, 8'h1A, 1'b1, 0, 0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    exp_q.push_back('{3'd1, 8'h1A, 1'b1, 0});
    exp_q.push_back('{3'd2, 8'h2A, 1'b1, 0});
    drive();
    wait_drain("post_reset_grant", 20);

    // Fixed priority: lanes 1, 2, 4 with 3-beat bursts; beats contiguous, 1 bubble between bursts.
    foreach (exp_q[i]) exp_q.delete(i);
    for (int j = 0; j < 3; j++) load(1, 8'(16 + j + 1), j == 2, 0, (j == 0) ? 0 : 1);
    for (int j = 0; j < 3; j++) load(2, 8'(32 + j + 1), j == 2, 0, (j == 0) ? 2 : 1);
    for (int j = 0; j < 3; j++) load(4, 8'(64 + j + 1), j == 2, 0, (j == 0) ? 2 : 1);
    drive();
    wait_drain("fixed_priority", 40);

    // Backpressure on lane 0: first beat must hold and lane 0 must not be readied.
    load(0, 8'h11, 1'b0, 0, 0);
    load(0, 8'h22, 1'b0, 0, 0);
    load(0, 8'h33, 1'b1, 0, 0);
    drive();
    k = 0;
    while (!out_valid && k < 10) begin cycle(); k++; end
    if (!out_valid) fail_timeout("bp_first_beat");
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_data",  32'(out_data), 32'h11);
      check("bp_req_ready0", 32'(req_ready[0]), 0);
    end
    out_ready = 1'b1;
    wait_drain("backpressure", 20);
    check("bp_source_empty", 32'(src_q[0].size()), 0);

    // Locked lane: lane 3 goes quiet mid-burst while lane 0 waits.
    load(3, 8'h31, 1'b0, 0, 0);
    load(3, 8'h32, 1'b0, 6, 0);
    load(3, 8'h33, 1'b1, 0, 0);
    drive();
    k = 0;
    while (!busy && k < 10) begin cycle(); k++; end
    if (!busy) fail_timeout("lock_grant");
    load(0, 8'h01, 1'b1, 0, 0);
    drive();
    for (int j = 0; j < 6; j++) begin
      cycle();
      check("lock_busy",       32'(busy), 1);
      check("lock_req_ready0", 32'(req_ready[0]), 0);
    end
    wait_drain("locked_lane", 30);

    k = 0;
    while ((exp_a.size() != 0 || exp_f.size() != 0) && k < 50) begin cycle(); k++; end
    check("main_queue_empty",  32'(exp_q.size()), 0);
    check("aged_queue_empty",  32'(exp_a.size()), 0);
    check("fixed_queue_empty", 32'(exp_f.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
